fetch_unit: RTL and testbench

Instruction-fetch front end of the 5-stage pipeline, including the F/D pipeline register. It is the consumer of the hazard unit's `stall_F`, `stall_D`, `flush_D` and the E-stage redirect. It issues PC requests to a variable-latency instruction memory over a valid/ready handshake and buffers returned instructions. It delivers them to the D stage, discarding responses made stale by a taken branch or jump.

---
 rtl/riscv_pkg.sv | 9 +
 rtl/fetch_unit_if.sv | 14 +
 rtl/fetch_fifo.sv | 51 +++++
 rtl/fetch_unit.sv | 111 +++++++++++
 tb/tb_fetch_unit.sv | 266 ++++++++++++++++++++++++++
 5 files changed

// File: rtl/riscv_pkg.sv
// riscv_pkg: shared pipeline constants and the fetch buffer entry type.
package riscv_pkg;
    localparam int XLEN = 32;
    localparam logic [XLEN-1:0] NOP_INSTR = 32'h0000_0013;
    typedef struct packed {
        logic [XLEN-1:0] instr;
        logic [XLEN-1:0] pc;
    } fetch_entry_t;
endpackage

// File: rtl/fetch_unit_if.sv
// fetch_unit_if: instruction memory request/response handshake.
//   req_valid/req_addr/req_ready : fetch request, accepted on valid && ready
//   rsp_valid/rsp_data           : in-order response strobe and instruction word
//   master = fetch side, slave = memory side
interface fetch_unit_if;
    import riscv_pkg::*;
    logic            req_valid;
    logic [XLEN-1:0] req_addr;
    logic            req_ready;
    logic            rsp_valid;
    logic [XLEN-1:0] rsp_data;
    modport master (output req_valid, req_addr, input req_ready, rsp_valid, rsp_data);
    modport slave  (input req_valid, req_addr, output req_ready, rsp_valid, rsp_data);
endinterface

// File: rtl/fetch_fifo.sv
// fetch_fifo: circular FIFO with synchronous clear.
//   clk, rst_n      : clock, async active-low reset
//   clr             : empty the FIFO at the next edge (wins over push/pop)
//   push, push_data : write an entry (ignored when full)
//   pop             : drop the head entry (ignored when empty)
//   head, count, empty : head entry, occupancy, empty flag
module fetch_fifo #(
    parameter int WIDTH = 64,
    parameter int DEPTH = 2
) (
    input  logic                       clk,
    input  logic                       rst_n,
    input  logic                       clr,
    input  logic                       push,
    input  logic                       pop,
    input  logic [WIDTH-1:0]           push_data,
    output logic [WIDTH-1:0]           head,
    output logic [$clog2(DEPTH+1)-1:0] count,
    output logic                       empty
);
    localparam int PW = DEPTH > 1 ? $clog2(DEPTH) : 1;
    localparam int CW = $clog2(DEPTH + 1);
    logic [WIDTH-1:0] mem_q [DEPTH];
    logic [PW-1:0]    rd_q, rd_d, wr_q, wr_d;
    logic [CW-1:0]    count_q, count_d;
    logic             do_push, do_pop;
    always_comb begin
        do_push = push && !clr && (count_q != CW'(DEPTH));
        do_pop  = pop && !clr && (count_q != '0);
        rd_d    = clr ? '0 : do_pop ? (rd_q == PW'(DEPTH - 1) ? '0 : rd_q + PW'(1)) : rd_q;
        wr_d    = clr ? '0 : do_push ? (wr_q == PW'(DEPTH - 1) ? '0 : wr_q + PW'(1)) : wr_q;
        count_d = clr ? '0 : count_q + CW'(do_push) - CW'(do_pop);
    end
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            rd_q    <= '0;
            wr_q    <= '0;
            count_q <= '0;
        end else begin
            rd_q    <= rd_d;
            wr_q    <= wr_d;
            count_q <= count_d;
        end
    end
    always_ff @(posedge clk) begin
        if (do_push) mem_q[wr_q] <= push_data;
    end
    assign head  = mem_q[rd_q];
    assign count = count_q;
    assign empty = count_q == '0;
endmodule

// File: rtl/fetch_unit.sv
// fetch_unit: instruction fetch front end with response buffer and F/D register.
//   clk, rst_n                 : clock, async active-low reset
//   stall_F, stall_D, flush_D  : hazard unit controls
//   pc_src_E, pc_target_E      : E-stage redirect
//   imem                       : instruction memory handshake (master)
//   instr_D, pc_D, pc_plus4_D, valid_D : F/D register outputs
module fetch_unit
    import riscv_pkg::*;
#(
    parameter logic [XLEN-1:0] RESET_PC   = 32'h0000_0000,
    parameter int              FIFO_DEPTH = 2
) (
    input  logic            clk,
    input  logic            rst_n,
    input  logic            stall_F,
    input  logic            stall_D,
    input  logic            flush_D,
    input  logic            pc_src_E,
    input  logic [XLEN-1:0] pc_target_E,
    fetch_unit_if.master    imem,
    output logic [XLEN-1:0] instr_D,
    output logic [XLEN-1:0] pc_D,
    output logic [XLEN-1:0] pc_plus4_D,
    output logic            valid_D
);
    localparam int CW = $clog2(FIFO_DEPTH + 1);
    localparam int TW = XLEN + 1;
    logic [XLEN-1:0] pc_f_q, pc_f_d;
    logic            epoch_q, epoch_d;
    logic [XLEN-1:0] fd_instr_q, fd_instr_d, fd_pc_q, fd_pc_d, fd_pc4_q, fd_pc4_d;
    logic            fd_valid_q, fd_valid_d;
    logic [TW-1:0]   tag_head;
    logic [CW-1:0]   tag_count, buf_count;
    logic            tag_empty, buf_empty;
    fetch_entry_t    buf_head, buf_in, ld;
    logic            req_valid, accept, rsp_fire, rsp_ok, d_adv, hold;
    logic            bypass, buf_push, buf_pop, load;

    // In-flight tags {epoch, pc}; never cleared so stale requests keep their credit until they return.
    fetch_fifo #(.WIDTH(TW), .DEPTH(FIFO_DEPTH)) u_tag (
        .clk       (clk),
        .rst_n     (rst_n),
        .clr       (1'b0),
        .push      (accept),
        .pop       (rsp_fire),
        .push_data ({epoch_q, pc_f_q}),
        .head      (tag_head),
        .count     (tag_count),
        .empty     (tag_empty)
    );

    fetch_fifo #(.WIDTH($bits(fetch_entry_t)), .DEPTH(FIFO_DEPTH)) u_buf (
        .clk       (clk),
        .rst_n     (rst_n),
        .clr       (pc_src_E),
        .push      (buf_push),
        .pop       (buf_pop),
        .push_data (buf_in),
        .head      (buf_head),
        .count     (buf_count),
        .empty     (buf_empty)
    );

    always_comb begin
        // Credits cover both in-flight and buffered words, so the buffer can never overflow.
        req_valid  = !stall_F && ((CW+1)'(tag_count) + (CW+1)'(buf_count) < (CW+1)'(FIFO_DEPTH));
        accept     = req_valid && imem.req_ready;
        // A strobe with no tag pending is a leftover from before reset.
        rsp_fire   = imem.rsp_valid && !tag_empty;
        rsp_ok     = rsp_fire && !pc_src_E && (tag_head[XLEN] == epoch_q);
        d_adv      = !stall_D && !flush_D && !pc_src_E;
        hold       = stall_D && !flush_D && !pc_src_E;
        buf_pop    = d_adv && !buf_empty;
        bypass     = rsp_ok && buf_empty && d_adv;
        buf_push   = rsp_ok && !bypass;
        buf_in     = '{instr: imem.rsp_data, pc: tag_head[XLEN-1:0]};
        ld         = buf_pop ? buf_head : buf_in;
        load       = buf_pop || bypass;
        pc_f_d     = pc_src_E ? pc_target_E : accept ? pc_f_q + XLEN'(4) : pc_f_q;
        epoch_d    = epoch_q ^ pc_src_E;
        fd_valid_d = hold ? fd_valid_q : load;
        fd_instr_d = hold ? fd_instr_q : load ? ld.instr : NOP_INSTR;
        fd_pc_d    = hold ? fd_pc_q : load ? ld.pc : '0;
        fd_pc4_d   = hold ? fd_pc4_q : load ? ld.pc + XLEN'(4) : '0;
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            pc_f_q     <= RESET_PC;
            epoch_q    <= 1'b0;
            fd_valid_q <= 1'b0;
            fd_instr_q <= NOP_INSTR;
            fd_pc_q    <= '0;
            fd_pc4_q   <= '0;
        end else begin
            pc_f_q     <= pc_f_d;
            epoch_q    <= epoch_d;
            fd_valid_q <= fd_valid_d;
            fd_instr_q <= fd_instr_d;
            fd_pc_q    <= fd_pc_d;
            fd_pc4_q   <= fd_pc4_d;
        end
    end

    assign imem.req_valid = req_valid;
    assign imem.req_addr  = pc_f_q;
    assign instr_D        = fd_instr_q;
    assign pc_D           = fd_pc_q;
    assign pc_plus4_D     = fd_pc4_q;
    assign valid_D        = fd_valid_q;
endmodule

// File: tb/tb_fetch_unit.sv
// tb_fetch_unit: directed scoreboard bench for fetch_unit with a variable-latency memory model.
module tb_fetch_unit;
    import riscv_pkg::*;

    logic        clk = 1'b0;
    logic        rst_n;
    logic        stall_F, stall_D, flush_D, pc_src_E;
    logic [31:0] pc_target_E;
    logic [31:0] instr_D, pc_D, pc_plus4_D;
    logic        valid_D;

    fetch_unit_if imem ();

    fetch_unit #(.RESET_PC(32'h0000_0000), .FIFO_DEPTH(2)) dut (
        .clk         (clk),
        .rst_n       (rst_n),
        .stall_F     (stall_F),
        .stall_D     (stall_D),
        .flush_D     (flush_D),
        .pc_src_E    (pc_src_E),
        .pc_target_E (pc_target_E),
        .imem        (imem),
        .instr_D     (instr_D),
        .pc_D        (pc_D),
        .pc_plus4_D  (pc_plus4_D),
        .valid_D     (valid_D)
    );

    always #5 clk = ~clk;

    typedef struct {
        logic [31:0] addr;
        int          due;
    } pend_t;

    pend_t       pend[$];
    logic [31:0] exp_q[$];
    int          vectors = 0;
    int          miscompares = 0;
    int          lat = 1;
    int          cyc = 0;
    int          last_due = 0;
    bit          inject = 0;

    function automatic logic [31:0] mem_word(logic [31:0] a);
        return 32'hA500_0000 ^ a;
    endfunction

    task automatic check(string name, logic [31:0] act, logic [31:0] exp);
        vectors++;
        if (act !== exp) begin
            miscompares++;
            $display("FAIL %s: got %h, expected %h", name, act, exp);
        end
    endtask

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic expect_from(logic [31:0] pc, int n);
        exp_q.delete();
        for (int i = 0; i < n; i++) exp_q.push_back(pc + 32'(4 * i));
    endtask

    task automatic wait_valid(string name);
        int n = 0;
        while (!valid_D && n < 30) begin
            tick();
            n++;
        end
        check(name, 32'(valid_D), 32'd1);
    endtask

    // Memory model: responses in order, each at least lat cycles after acceptance.
    initial begin
        imem.rsp_valid = 1'b0;
        imem.rsp_data  = '0;
        forever begin
            @(posedge clk);
            #2;
            cyc++;
            if (!rst_n) pend.delete();
            if (inject) begin
                imem.rsp_valid = 1'b1;
                imem.rsp_data  = 32'hDEAD_BEEF;
                inject         = 0;
            end else if (pend.size() > 0 && pend[0].due <= cyc) begin
                imem.rsp_valid = 1'b1;
                imem.rsp_data  = mem_word(pend[0].addr);
                void'(pend.pop_front());
            end else begin
                imem.rsp_valid = 1'b0;
            end
        end
    end

    initial begin
        forever begin
            @(negedge clk);
            if (rst_n && imem.req_valid && imem.req_ready) begin
                last_due = (cyc + lat > last_due + 1) ? cyc + lat : last_due + 1;
                pend.push_back('{imem.req_addr, last_due});
            end
        end
    end

    // Monitor: every fresh valid D-stage load pops the scoreboard; stalls must hold, flushes must bubble.
    initial begin
        logic        p_stall, p_flush, l_valid;
        logic [31:0] l_instr, l_pc, l_pc4, e;
        p_stall = 0;
        p_flush = 0;
        forever begin
            @(negedge clk);
            if (!rst_n) begin
                p_stall = 0;
                p_flush = 0;
            end else begin
                if (p_flush) check("bubble_after_flush", 32'(valid_D), 32'd0);
                else if (p_stall) begin
                    check("hold_instr_D", instr_D, l_instr);
                    check("hold_pc_D", pc_D, l_pc);
                    check("hold_pc_plus4_D", pc_plus4_D, l_pc4);
                    check("hold_valid_D", 32'(valid_D), 32'(l_valid));
                end else if (valid_D) begin
                    if (exp_q.size() == 0) begin
                        vectors++;
                        miscompares++;
                        $display("FAIL unexpected_delivery: got pc %h, expected no instruction", pc_D);
                    end else begin
                        e = exp_q.pop_front();
                        check("sb_pc_D", pc_D, e);
                        check("sb_instr_D", instr_D, mem_word(e));
                        check("sb_pc_plus4_D", pc_plus4_D, e + 32'd4);
                    end
                end
                p_stall = stall_D;
                p_flush = flush_D || pc_src_E;
            end
            l_instr = instr_D;
            l_pc    = pc_D;
            l_pc4   = pc_plus4_D;
            l_valid = valid_D;
        end
    end

    initial begin
        #100000;
        $display("FAIL global_timeout: got no end of stimulus, expected finish");
        $fatal(1);
    end

    initial begin
        int n;
        stall_F = 0; stall_D = 0; flush_D = 0; pc_src_E = 0; pc_target_E = '0;
        imem.req_ready = 1'b1;
        rst_n = 1'b0;
        expect_from(32'h0, 64);
        repeat (3) @(posedge clk);
        #3;
        check("rst_valid_D", 32'(valid_D), 32'd0);
        check("rst_instr_D", instr_D, 32'h13);
        check("rst_pc_D", pc_D, 32'h0);
        check("rst_pc_plus4_D", pc_plus4_D, 32'h0);
        check("rst_req_addr", imem.req_addr, 32'h0);
        tick();
        rst_n = 1'b1;
        // Streaming, 1-cycle memory: cycle k fetches 4k, D shows 4(k-2).
        for (int i = 0; i < 4; i++) begin
            if (i > 0) tick();
            #3;
            check("stream_req_addr", imem.req_addr, 32'(4 * i));
            check("stream_req_valid", 32'(imem.req_valid), 32'd1);
            if (i >= 2) begin
                check("stream_pc_D", pc_D, 32'(4 * (i - 2)));
                check("stream_valid_D", 32'(valid_D), 32'd1);
            end
        end
        // Load-use stall for two cycles while pc_D = 8.
        tick();
        stall_F = 1; stall_D = 1;
        check("stall_entry_pc_D", pc_D, 32'h8);
        #3 check("stall_req_valid", 32'(imem.req_valid), 32'd0);
        tick();
        #3 check("stall_req_valid", 32'(imem.req_valid), 32'd0);
        check("stall_held_pc_D", pc_D, 32'h8);
        tick();
        stall_F = 0; stall_D = 0;
        tick();
        check("after_stall_pc_D", pc_D, 32'hC);
        check("after_stall_valid_D", 32'(valid_D), 32'd1);
        tick();
        check("after_stall_next_pc_D", pc_D, 32'h10);
        // Backpressure for three cycles.
        tick();
        imem.req_ready = 1'b0;
        #3 check("bp_req_addr", imem.req_addr, 32'h1C);
        tick();
        #3 check("bp_req_addr", imem.req_addr, 32'h1C);
        tick();
        #3 check("bp_req_addr", imem.req_addr, 32'h1C);
        check("bp_bubble_valid_D", 32'(valid_D), 32'd0);
        tick();
        imem.req_ready = 1'b1;
        check("bp_bubble_valid_D", 32'(valid_D), 32'd0);
        tick();
        tick();
        check("bp_resume_pc_D", pc_D, 32'h1C);
        check("bp_resume_valid_D", 32'(valid_D), 32'd1);
        // Redirect to 0x10 with a 3-cycle memory, then to 0x100 while 0x10 and 0x14 are in flight.
        tick();
        pc_src_E = 1; pc_target_E = 32'h10; stall_F = 1; lat = 3;
        @(negedge clk);
        #1 expect_from(32'h100, 64);
        tick();
        pc_src_E = 0; stall_F = 0;
        #3 check("redir1_req_addr", imem.req_addr, 32'h10);
        n = 0;
        while (!(pend.size() == 2 && pend[0].addr == 32'h10 && pend[1].addr == 32'h14) && n < 20) begin
            tick();
            n++;
        end
        check("redir_stale_pair_in_flight", 32'(n < 20), 32'd1);
        pc_src_E = 1; pc_target_E = 32'h100;
        @(negedge clk);
        #1 expect_from(32'h100, 64);
        tick();
        pc_src_E = 0;
        #3 check("redir2_req_addr", imem.req_addr, 32'h100);
        check("redir2_no_credit", 32'(imem.req_valid), 32'd0);
        wait_valid("redir2_wait_valid");
        check("redir2_first_pc_D", pc_D, 32'h100);
        check("redir2_first_instr_D", instr_D, mem_word(32'h100));
        repeat (6) tick();
        // Reset with two responses outstanding.
        n = 0;
        while (pend.size() != 2 && n < 20) begin
            tick();
            n++;
        end
        check("rst2_two_outstanding", 32'(pend.size()), 32'd2);
        @(posedge clk);
        #3 rst_n = 1'b0;
        #1;
        check("rst2_valid_D", 32'(valid_D), 32'd0);
        check("rst2_instr_D", instr_D, 32'h13);
        check("rst2_pc_D", pc_D, 32'h0);
        check("rst2_pc_plus4_D", pc_plus4_D, 32'h0);
        check("rst2_req_addr", imem.req_addr, 32'h0);
        expect_from(32'h0, 64);
        tick();
        tick();
        rst_n = 1'b1;
        inject = 1;
        #3 check("rst2_restart_addr", imem.req_addr, 32'h0);
        check("rst2_restart_valid", 32'(imem.req_valid), 32'd1);
        wait_valid("rst2_wait_valid");
        check("rst2_first_pc_D", pc_D, 32'h0);
        check("rst2_first_instr_D", instr_D, mem_word(32'h0));
        repeat (8) tick();
        $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
        $finish;
    end
endmodule
